// File: rtl/pwm_audio_pkg.sv
// Shared definitions for the PWM audio output path.
//
// Contents:
//   DEFAULT_N       default PWM resolution (duty values are N+1 bits wide)
//   DEFAULT_DATA_W  default width of signed audio samples
//   midscale(n)     duty value for silence, 2^(n-1)
//   to_duty(...)    signed sample -> rounded unsigned duty value (0..2^n)
package pwm_audio_pkg;

    localparam int DEFAULT_N      = 10;
    localparam int DEFAULT_DATA_W = 16;

    function automatic int unsigned midscale(input int unsigned n);
        return 32'd1 << (n - 1);
    endfunction

    // Inverting the sign bit maps two's complement onto offset binary.
    // Adding half an output LSB before the shift rounds to nearest. The
    // work is done in 33 bits so the rounding add can carry one bit past
    // the sample width, which is how the value 2^n (always-high) arises.
    // Only the low data_w bits of 'sample' are used.
    function automatic logic [31:0] to_duty(input logic [31:0] sample,
                                            input int data_w = DEFAULT_DATA_W,
                                            input int n      = DEFAULT_N);
        logic [32:0] mask;
        logic [32:0] u;
        logic [32:0] r;
        mask = (33'd1 << data_w) - 33'd1;
        u    = ({1'b0, sample} ^ (33'd1 << (data_w - 1))) & mask;
        r    = (u + (33'd1 << (data_w - n - 1))) >> (data_w - n);
        return r[31:0];
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO holding audio samples between the filter chain and
// the PWM period boundary.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset (clears contents)
//   push, wr_data  write request; ignored when full
//   pop            read request; ignored when empty
//   rd_data        current head of the FIFO (valid when not empty)
//   full, empty    combinational from the registered occupancy only
//   level          registered occupancy, 0..DEPTH
module sample_fifo
    import pwm_audio_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic              do_push;
    logic              do_pop;

    always_comb begin
        full     = (level_q == (AW+1)'(DEPTH));
        empty    = (level_q == '0);
        // A full FIFO refuses a push even if a pop happens in the same cycle.
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            // DEPTH is a power of two, so pointers wrap naturally.
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign level   = level_q;

endmodule

// File: rtl/pwm_sample_feeder.sv
// Feeds one duty value per PWM period to the PWM output stage.
//
// Samples arrive from the filter chain over a valid/ready handshake and are
// buffered in sample_fifo. A free-running N-bit period counter, reset and
// clocked together with the PWM stage, marks the last cycle of each period
// (the boundary). On the boundary the FIFO head is popped and its rounded
// duty value registered, so the new value appears exactly when the PWM
// counter wraps to 0 and holds for the whole period.
//
// Handshake: a sample transfers on any cycle where s_valid && s_ready.
// s_ready depends only on registered occupancy, never on s_valid or mute.
//
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset (shared with PWM)
//   s_data/s_valid/s_ready  signed sample input handshake
//   mute           forces midscale from the next boundary, discarding a sample
//   duty_val       duty value to PWM stage, 0..2^N
//   sample_tick    one-cycle pulse: a sample was popped at the last boundary
//   underrun       one-cycle pulse: FIFO was empty at the last boundary
//   underrun_cnt   saturating count of underruns
//   fill_level     registered FIFO occupancy
module pwm_sample_feeder
    import pwm_audio_pkg::*;
#(
    parameter int N      = DEFAULT_N,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DATA_W-1:0]        s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     mute,
    output logic [N:0]               duty_val,
    output logic                     sample_tick,
    output logic                     underrun,
    output logic [7:0]               underrun_cnt,
    output logic [$clog2(DEPTH):0]   fill_level
);

    localparam logic [N:0] MIDSCALE = (N+1)'(midscale(N));

    logic [N-1:0]      cnt_q, cnt_d;
    logic [N:0]        duty_q, duty_d;
    logic              tick_q, tick_d;
    logic              under_q, under_d;
    logic [7:0]        ucnt_q, ucnt_d;

    logic              boundary;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic [N:0]        head_duty;

    sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .wr_data (s_data),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fill_level)
    );

    always_comb begin
        boundary  = (cnt_q == '1);
        s_ready   = !fifo_full;
        fifo_push = s_valid && s_ready;
        // A push landing on a boundary into an empty FIFO is not bypassed:
        // the pop decision uses the registered empty flag only.
        fifo_pop  = boundary && !fifo_empty;
        head_duty = (N+1)'(to_duty(32'(fifo_head), DATA_W, N));
    end

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        duty_d  = duty_q;
        tick_d  = 1'b0;
        under_d = 1'b0;
        ucnt_d  = ucnt_q;
        if (boundary) begin
            if (fifo_empty) begin
                under_d = 1'b1;
                if (ucnt_q != 8'hFF) begin
                    ucnt_d = ucnt_q + 1'b1;
                end
            end else begin
                tick_d = 1'b1;
                duty_d = head_duty;
            end
            // Mute wins over both cases: any popped sample is dropped.
            if (mute) begin
                duty_d = MIDSCALE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            duty_q  <= MIDSCALE;
            tick_q  <= 1'b0;
            under_q <= 1'b0;
            ucnt_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            tick_q  <= tick_d;
            under_q <= under_d;
            ucnt_q  <= ucnt_d;
        end
    end

    assign duty_val     = duty_q;
    assign sample_tick  = tick_q;
    assign underrun     = under_q;
    assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_pwm_sample_feeder.sv
// Bench for pwm_sample_feeder, run with N=6 so that hundreds of PWM periods
// fit in a short simulation. Expected values come from a queue-based model
// advanced once per clock by tick().
module tb_pwm_sample_feeder;

    localparam int N      = 6;
    localparam int DW     = 16;
    localparam int DEPTH  = 4;
    localparam int LW     = $clog2(DEPTH) + 1;
    localparam int PERIOD = 1 << N;
    localparam int MID    = 1 << (N - 1);
    localparam int FULLSC = 1 << N;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          mute = 1'b0;
    logic [N:0]    duty_val;
    logic          sample_tick;
    logic          underrun;
    logic [7:0]    underrun_cnt;
    logic [LW-1:0] fill_level;

    always #5 clk = ~clk;

    pwm_sample_feeder #(
        .N      (N),
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .mute         (mute),
        .duty_val     (duty_val),
        .sample_tick  (sample_tick),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt),
        .fill_level   (fill_level)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int            exp_duty;
    int            exp_cnt;
    bit            exp_tick;
    bit            exp_under;
    int            phase;

    int n_checks = 0;
    int n_fail   = 0;

    // Rounded duty from the arithmetic definition: shift the signed value to
    // 0..2^DW-1, add half an output step, divide by the step size.
    function automatic int ref_duty(input logic [DW-1:0] s);
        int sv;
        sv = int'($signed(s));
        return ((sv + (1 << (DW - 1))) + (1 << (DW - N - 1))) / (1 << (DW - N));
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_duty  = MID;
        exp_cnt   = 0;
        exp_tick  = 1'b0;
        exp_under = 1'b0;
        phase     = 0;
    endtask

    // One clock: inputs are sampled as set before the edge, the model is
    // advanced, and control returns on the following negedge.
    task automatic tick();
        bit            bnd;
        bit            push_ok;
        bit            m;
        logic [DW-1:0] d;
        int            v;
        bnd     = (phase == PERIOD - 1);
        push_ok = s_valid && (exp_q.size() < DEPTH);
        m       = mute;
        d       = s_data;
        @(posedge clk);
        exp_tick  = 1'b0;
        exp_under = 1'b0;
        if (bnd) begin
            if (exp_q.size() > 0) begin
                v        = ref_duty(exp_q.pop_front());
                exp_tick = 1'b1;
                exp_duty = m ? MID : v;
            end else begin
                exp_under = 1'b1;
                if (exp_cnt < 255) exp_cnt++;
                if (m) exp_duty = MID;
            end
        end
        if (push_ok) exp_q.push_back(d);
        phase = (phase + 1) % PERIOD;
        @(negedge clk);
    endtask

    task automatic run_until_phase(input int p);
        while (phase != p) tick();
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            tick();
            run_until_phase(0);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int pulses;
        reset_n = 1'b0;
        s_valid = 1'b0;
        mute    = 1'b0;
        model_reset();
        @(negedge clk);
        n_checks++; if (duty_val !== MID) begin n_fail++; $display("FAIL reset_duty: got %0d expected %0d", duty_val, MID); end
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b expected 1", s_ready); end
        n_checks++; if (fill_level !== 0) begin n_fail++; $display("FAIL reset_fill: got %0d expected 0", fill_level); end
        n_checks++; if (underrun_cnt !== 0) begin n_fail++; $display("FAIL reset_ucnt: got %0d expected 0", underrun_cnt); end
        n_checks++; if (sample_tick !== 1'b0 || underrun !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got tick=%0b under=%0b expected 0 0", sample_tick, underrun); end
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < PERIOD - 1; i++) begin
            tick();
            if (underrun === 1'b1) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL early_underrun: got %0d pulses expected 0", pulses); end
        tick();
        n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL first_underrun: got %0b expected 1", underrun); end
        n_checks++; if (underrun_cnt !== 8'd1) begin n_fail++; $display("FAIL first_ucnt: got %0d expected 1", underrun_cnt); end
        n_checks++; if (duty_val !== MID) begin n_fail++; $display("FAIL first_duty: got %0d expected %0d", duty_val, MID); end
    endtask

    task automatic test_conversion();
        logic [DW-1:0] samples [12];
        int            fixed_exp [4];
        samples[0] = 16'h0000; fixed_exp[0] = MID;
        samples[1] = 16'h7FFF; fixed_exp[1] = FULLSC;
        samples[2] = 16'h8000; fixed_exp[2] = 0;
        samples[3] = 16'h0200; fixed_exp[3] = MID + 1;
        for (int i = 4; i < 12; i++) samples[i] = DW'($urandom_range(0, 65535));
        drain();
        run_until_phase(0);
        for (int i = 0; i < 12; i++) begin
            s_data  = samples[i];
            s_valid = 1'b1;
            tick();
            s_valid = 1'b0;
            while (phase != 0) begin
                tick();
                n_checks++; if (duty_val !== exp_duty) begin n_fail++; $display("FAIL conv_duty[%0d] phase %0d: got %0d expected %0d", i, phase, duty_val, exp_duty); end
                n_checks++; if (sample_tick !== exp_tick) begin n_fail++; $display("FAIL conv_tick[%0d] phase %0d: got %0b expected %0b", i, phase, sample_tick, exp_tick); end
            end
            n_checks++; if (sample_tick !== 1'b1) begin n_fail++; $display("FAIL conv_pop[%0d]: got %0b expected 1", i, sample_tick); end
            if (i < 4) begin
                n_checks++; if (duty_val !== fixed_exp[i]) begin n_fail++; $display("FAIL conv_fixed[%0d] sample %h: got %0d expected %0d", i, samples[i], duty_val, fixed_exp[i]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        drain();
        run_until_phase(0);
        for (int i = 0; i < 5; i++) begin
            s_data  = DW'($urandom_range(0, 65535));
            s_valid = 1'b1;
            tick();
            n_checks++; if (fill_level !== exp_q.size()) begin n_fail++; $display("FAIL b2b_fill[%0d]: got %0d expected %0d", i, fill_level, exp_q.size()); end
            n_checks++; if (s_ready !== (exp_q.size() < DEPTH)) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %0b expected %0b", i, s_ready, exp_q.size() < DEPTH); end
        end
        s_valid = 1'b0;
        n_checks++; if (fill_level !== DEPTH || s_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full: got fill=%0d ready=%0b expected %0d 0", fill_level, s_ready, DEPTH); end
        run_until_phase(0);
        n_checks++; if (fill_level !== DEPTH - 1 || s_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_after_pop: got fill=%0d ready=%0b expected %0d 1", fill_level, s_ready, DEPTH - 1); end
        n_checks++; if (duty_val !== exp_duty || sample_tick !== 1'b1) begin n_fail++; $display("FAIL b2b_first_duty: got %0d tick=%0b expected %0d 1", duty_val, sample_tick, exp_duty); end
        while (exp_q.size() > 0) begin
            tick();
            run_until_phase(0);
            n_checks++; if (duty_val !== exp_duty) begin n_fail++; $display("FAIL b2b_drain_duty: got %0d expected %0d", duty_val, exp_duty); end
        end
    endtask

    task automatic test_underrun_saturation();
        int pulses;
        int changes;
        logic [N:0] held;
        drain();
        run_until_phase(0);
        held    = duty_val;
        pulses  = 0;
        changes = 0;
        for (int i = 0; i < 300 * PERIOD; i++) begin
            tick();
            if (underrun === 1'b1) pulses++;
            if (duty_val !== held) changes++;
        end
        n_checks++; if (pulses != 300) begin n_fail++; $display("FAIL sat_pulses: got %0d expected 300", pulses); end
        n_checks++; if (underrun_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_ucnt: got %0d expected 255", underrun_cnt); end
        n_checks++; if (changes != 0) begin n_fail++; $display("FAIL sat_duty_held: got %0d changes expected 0", changes); end
    endtask

    task automatic test_mute();
        drain();
        run_until_phase(0);
        s_data  = 16'h7FFF;
        s_valid = 1'b1;
        tick();
        tick();
        s_valid = 1'b0;
        mute    = 1'b1;
        run_until_phase(0);
        mute    = 1'b0;
        n_checks++; if (duty_val !== MID) begin n_fail++; $display("FAIL mute_duty: got %0d expected %0d", duty_val, MID); end
        n_checks++; if (sample_tick !== 1'b1) begin n_fail++; $display("FAIL mute_tick: got %0b expected 1", sample_tick); end
        n_checks++; if (fill_level !== 1) begin n_fail++; $display("FAIL mute_fill: got %0d expected 1", fill_level); end
        tick();
        run_until_phase(0);
        n_checks++; if (duty_val !== FULLSC || sample_tick !== 1'b1) begin n_fail++; $display("FAIL unmute_duty: got %0d tick=%0b expected %0d 1", duty_val, sample_tick, FULLSC); end
        mute = 1'b1;
        tick();
        run_until_phase(0);
        mute = 1'b0;
        n_checks++; if (duty_val !== MID || underrun !== 1'b1 || sample_tick !== 1'b0) begin n_fail++; $display("FAIL mute_empty: got duty=%0d under=%0b tick=%0b expected %0d 1 0", duty_val, underrun, sample_tick, MID); end
    endtask

    task automatic test_push_on_boundary();
        drain();
        run_until_phase(0);
        s_data  = 16'h8000;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        run_until_phase(0);
        run_until_phase(PERIOD - 1);
        s_data  = 16'h7FFF;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        n_checks++; if (underrun !== 1'b1 || sample_tick !== 1'b0) begin n_fail++; $display("FAIL pob_pulses: got under=%0b tick=%0b expected 1 0", underrun, sample_tick); end
        n_checks++; if (duty_val !== 0) begin n_fail++; $display("FAIL pob_held: got %0d expected 0", duty_val); end
        n_checks++; if (fill_level !== 1) begin n_fail++; $display("FAIL pob_fill: got %0d expected 1", fill_level); end
        tick();
        run_until_phase(0);
        n_checks++; if (duty_val !== FULLSC || sample_tick !== 1'b1) begin n_fail++; $display("FAIL pob_next: got %0d tick=%0b expected %0d 1", duty_val, sample_tick, FULLSC); end
    endtask

    task automatic test_random();
        int rate;
        for (int p = 0; p < 24; p++) begin
            rate = $urandom_range(0, 3);
            mute = ($urandom_range(0, 5) == 0);
            for (int c = 0; c < PERIOD; c++) begin
                s_valid = (rate != 0) && ($urandom_range(0, 15) < rate);
                s_data  = DW'($urandom_range(0, 65535));
                tick();
                n_checks++;
                if (duty_val !== exp_duty || sample_tick !== exp_tick || underrun !== exp_under ||
                    underrun_cnt !== exp_cnt || fill_level !== exp_q.size() || s_ready !== (exp_q.size() < DEPTH)) begin
                    n_fail++;
                    $display("FAIL rand p%0d c%0d: got duty=%0d tick=%0b under=%0b ucnt=%0d fill=%0d ready=%0b expected %0d %0b %0b %0d %0d %0b",
                             p, c, duty_val, sample_tick, underrun, underrun_cnt, fill_level, s_ready,
                             exp_duty, exp_tick, exp_under, exp_cnt, exp_q.size(), exp_q.size() < DEPTH);
                end
            end
        end
        s_valid = 1'b0;
        mute    = 1'b0;
    endtask

    task automatic test_reset_mid();
        drain();
        run_until_phase(0);
        s_data  = 16'h7FFF;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        run_until_phase(0);
        s_data  = 16'h1234;
        s_valid = 1'b1;
        tick();
        tick();
        s_valid = 1'b0;
        run_until_phase(20);
        reset_n = 1'b0;
        #1;
        n_checks++; if (duty_val !== MID) begin n_fail++; $display("FAIL rst_mid_duty: got %0d expected %0d", duty_val, MID); end
        n_checks++; if (fill_level !== 0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_fifo: got fill=%0d ready=%0b expected 0 1", fill_level, s_ready); end
        n_checks++; if (underrun_cnt !== 0) begin n_fail++; $display("FAIL rst_mid_ucnt: got %0d expected 0", underrun_cnt); end
        n_checks++; if (sample_tick !== 1'b0 || underrun !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pulses: got tick=%0b under=%0b expected 0 0", sample_tick, underrun); end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < PERIOD; i++) tick();
        n_checks++; if (underrun !== 1'b1 || underrun_cnt !== 8'd1 || duty_val !== MID) begin n_fail++; $display("FAIL rst_mid_after: got under=%0b ucnt=%0d duty=%0d expected 1 1 %0d", underrun, underrun_cnt, duty_val, MID); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_conversion();
        test_back_to_back();
        test_underrun_saturation();
        test_mute();
        test_push_on_boundary();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
